// File: rtl/run_ctrl.sv
// Run controller: preloads the core register file from a latched image, holds the core
// in reset, runs it until core_done or timeout, and reports pass/timeout with a cycle count.
module run_ctrl #(
    parameter int NUM_REGS      = 8,
    parameter int DW            = 8,
    parameter int AW            = $clog2(NUM_REGS),
    parameter int HOLD_CYCLES   = 2,
    parameter int TIMEOUT       = 500,
    parameter int SETTLE_CYCLES = 4,
    parameter int CW            = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_REGS*DW-1:0] init_data,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_wdata,
    output logic                   core_reset,
    input  logic                   core_done,
    output logic                   busy,
    output logic                   pass,
    output logic                   timeout,
    output logic [CW-1:0]          cycle_count
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_HOLD,
        S_RUN,
        S_SETTLE,
        S_PASS,
        S_TOUT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    cycle_q, cycle_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]    rf_wdata_q, rf_wdata_d;
    logic [DW-1:0]    image_q [NUM_REGS];
    logic [DW-1:0]    image_d [NUM_REGS];
    logic [AW-1:0]    rf_idx;

    assign rf_idx = cnt_q[AW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cycle_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                image_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cycle_q    <= cycle_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                image_q[i] <= image_d[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cycle_d    = cycle_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            image_d[i] = image_q[i];
        end

        case (state_q)
            S_IDLE, S_PASS, S_TOUT: begin
                if (start) begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        image_d[i] = init_data[i*DW +: DW];
                    end
                    cycle_d = '0;
                    cnt_d   = '0;
                    state_d = S_PRELOAD;
                end
            end
            // First PRELOAD cycle only primes the write pipeline; the registered
            // writes then appear on NUM_REGS consecutive cycles.
            S_PRELOAD: begin
                if (cnt_q < CNT_W'(NUM_REGS)) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = rf_idx;
                    rf_wdata_d = image_q[rf_idx];
                    cnt_d      = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Done takes priority over the timeout limit in the same cycle.
            S_RUN: begin
                if (core_done) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (cycle_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_TOUT;
                end else begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_PASS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign cycle_count = cycle_q;
    assign core_reset  = !((state_q == S_RUN) || (state_q == S_SETTLE));
    assign busy        = (state_q == S_PRELOAD) || (state_q == S_HOLD) ||
                         (state_q == S_RUN)     || (state_q == S_SETTLE);
    assign pass        = (state_q == S_PASS);
    assign timeout     = (state_q == S_TOUT);

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Synthesizable run controller that sits between the top-level harness and the microprocessor core.
- Preloads the core register file from a parallel image, then holds the core in reset for a programmable interval.
- Releases the core, watches `core_done`, and reports either pass or timeout, together with a cycle count.
- Supports repeated runs without a global reset. Sized for an N-entry, W-bit register file.

Parameters:
- NUM_REGS, 8, number of register-file entries to preload.
- DW, 8, register data width in bits.
- AW, $clog2(NUM_REGS), register address width (derived).
- HOLD_CYCLES, 2, cycles `core_reset` stays asserted after preload (≥1).
- TIMEOUT, 500, maximum RUN cycles before timeout (≥2).
- SETTLE_CYCLES, 4, cycles waited after `done` before `pass` is flagged (≥1).
- CW, $clog2(TIMEOUT+1), cycle-counter width (derived).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  run request, sampled only in IDLE/PASS/TOUT.
- init_data  input  NUM_REGS*DW  preload image; entry i = bits [i*DW +: DW].
- rf_we  output  1  register-file write enable.
- rf_waddr  output  AW  register-file write address.
- rf_wdata  output  DW  register-file write data.
- core_reset  output  1  active-high reset to the core.
- core_done  input  1  core completion flag.
- busy  output  1  high in PRELOAD, HOLD, RUN, SETTLE.
- pass  output  1  high in PASS.
- timeout  output  1  high in TOUT.
- cycle_count  output  CW  RUN cycles elapsed; frozen at done/timeout.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state=IDLE, core_reset=1, rf_we=0, rf_waddr=0, rf_wdata=0.
  - busy=0, pass=0, timeout=0, cycle_count=0.
  - The internal image register is cleared.
  - Reset asserted mid-run aborts immediately to these values.
- **States:** IDLE, PRELOAD, HOLD, RUN, SETTLE, PASS, TOUT.
- **Start (IDLE/PASS/TOUT):**
  - start=1 latches init_data into the image register, clears cycle_count, pass and timeout, then enters PRELOAD.
  - start while busy is ignored.
- **PRELOAD:**
  - One write per cycle: rf_we=1, rf_waddr=k, rf_wdata=image[k] for k=0..NUM_REGS-1.
  - Writes are registered outputs and occupy exactly NUM_REGS cycles.
  - After the last write, rf_we drops and the state goes to HOLD.
  - init_data changes after the start cycle have no effect.
- **HOLD:**
  - core_reset=1 for HOLD_CYCLES cycles, then RUN.
  - core_reset is 1 in every state except RUN and SETTLE.
- **RUN:**
  - core_reset=0; cycle_count increments by 1 each cycle, starting from 0 on the first RUN cycle.
  - core_done=1 sampled → freeze cycle_count, go to SETTLE.
  - Else if cycle_count==TIMEOUT-1 → TOUT; cycle_count ends at TIMEOUT-1 and never wraps.
  - core_done and the timeout condition in the same cycle: done wins, go to SETTLE.
  - core_done is ignored outside RUN, including during HOLD.
- **SETTLE:**
  - core_reset stays 0 for SETTLE_CYCLES cycles.
  - core_done deasserting during SETTLE is ignored.
  - Then go to PASS.
- **PASS/TOUT:**
  - pass or timeout held high and core_reset=1 until the next start or reset.
  - cycle_count stays frozen.
- **Latency:** start edge to first RUN cycle = 1 + NUM_REGS + HOLD_CYCLES cycles.

Test Plan:
- Default parameters, init_data = {05,04,03,02,05,04,03,02} (entry0 = 02):
  - rf writes on 8 consecutive cycles, addr 0..7, data 02,03,04,05,02,03,04,05.
  - core_reset falls exactly 2 cycles after the last write.
- Model core raises done on RUN cycle 37:
  - cycle_count=37 frozen.
  - pass=1 exactly 4 cycles later.
  - busy=0, timeout=0.
- core_done held 0:
  - timeout=1 after 500 RUN cycles, cycle_count=499.
  - core_reset=1, pass=0.
- core_done rises on the cycle where cycle_count=499:
  - SETTLE entered, then pass=1, timeout=0.
- reset pulsed low mid-PRELOAD (after 3 writes), then start reissued:
  - all outputs return to reset values immediately.
  - New run rewrites from address 0.
- start pulsed during RUN ignored; start after PASS with a new image:
  - pass clears, full preload of the new data, cycle_count restarts at 0.
